// File: rtl/lat_sequencer.sv
// lat_sequencer: command-driven LAT / data-phase timing generator for a daisy
// chain of LED drivers, stepped by rising edges of an externally generated SCLK.
module lat_sequencer #(
  parameter int N_DRIVERS   = 1,
  parameter int WORD_BITS   = 48,
  parameter int FCWRTEN_LEN = 15,
  parameter int WRTFC_LEN   = 5,
  parameter int FC_ON_RESET = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCLK,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  output logic       cmd_ready,
  input  logic       force_fc,
  output logic       en,
  output logic       LAT,
  output logic       data_phase,
  output logic       done
);

  localparam int DATA_LEN = WORD_BITS * N_DRIVERS;
  localparam int CNT_W    = $clog2(FCWRTEN_LEN + DATA_LEN + 2);

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    MODE_FC        = 2'd0,
    MODE_WRTGS     = 2'd1,
    MODE_LATGS     = 2'd2,
    MODE_LINERESET = 2'd3
  } mode_t;

  // Window edges of the FC frame (FCWRTEN, data, WRTFC) and of the data frames.
  localparam cnt_t CNT_ONE      = cnt_t'(1);
  localparam cnt_t FC_LAST      = cnt_t'(FCWRTEN_LEN + DATA_LEN + 1);
  localparam cnt_t FC_EN_END    = cnt_t'(FCWRTEN_LEN);
  localparam cnt_t FC_DATA_BEG  = cnt_t'(FCWRTEN_LEN + 1);
  localparam cnt_t FC_WRT_BEG   = cnt_t'(FCWRTEN_LEN + DATA_LEN + 1 - WRTFC_LEN);
  localparam cnt_t FC_WIN_END   = cnt_t'(FCWRTEN_LEN + DATA_LEN);
  localparam cnt_t DATA_END     = cnt_t'(DATA_LEN);
  localparam cnt_t DATA_LAST    = cnt_t'(DATA_LEN + 1);
  localparam cnt_t LAT_BEG_GS   = cnt_t'(DATA_LEN);
  localparam cnt_t LAT_BEG_LAT  = cnt_t'(DATA_LEN - 2);
  localparam cnt_t LAT_BEG_LINE = cnt_t'(DATA_LEN - 6);

  mode_t mode;
  cnt_t  counter;
  cnt_t  last_cnt;
  cnt_t  lat_beg;
  logic  prev_sclk;
  logic  posedge_sclk;

  assign posedge_sclk = SCLK & ~prev_sclk;
  assign cmd_ready    = ~en & ~force_fc;

  always_comb begin
    last_cnt = DATA_LAST;
    lat_beg  = LAT_BEG_GS;
    case (mode)
      MODE_FC:        last_cnt = FC_LAST;
      MODE_WRTGS:     lat_beg  = LAT_BEG_GS;
      MODE_LATGS:     lat_beg  = LAT_BEG_LAT;
      MODE_LINERESET: lat_beg  = LAT_BEG_LINE;
      default:        lat_beg  = LAT_BEG_GS;
    endcase
  end

  // Counts 0 and last fall outside every window, giving a low-LAT SCLK at each boundary.
  always_comb begin
    LAT        = 1'b0;
    data_phase = 1'b0;
    if (en) begin
      if (mode == MODE_FC) begin
        LAT        = ((counter >= CNT_ONE) && (counter <= FC_EN_END)) ||
                     ((counter >= FC_WRT_BEG) && (counter <= FC_WIN_END));
        data_phase = (counter >= FC_DATA_BEG) && (counter <= FC_WIN_END);
      end else begin
        LAT        = (counter >= lat_beg) && (counter <= DATA_END);
        data_phase = (counter >= CNT_ONE) && (counter <= DATA_END);
      end
    end
  end

  // force_fc outranks a frame end and a pending command; an aborted frame gives no done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter   <= '0;
      prev_sclk <= 1'b0;
      done      <= 1'b0;
      mode      <= MODE_FC;
      en        <= (FC_ON_RESET != 0);
    end else begin
      prev_sclk <= SCLK;
      done      <= 1'b0;
      if (force_fc) begin
        mode    <= MODE_FC;
        counter <= '0;
        en      <= 1'b1;
      end else if (cmd_valid && cmd_ready) begin
        mode    <= mode_t'(cmd);
        counter <= '0;
        en      <= 1'b1;
      end else if (en && posedge_sclk) begin
        if (counter == last_cnt) begin
          en      <= 1'b0;
          counter <= '0;
          done    <= 1'b1;
        end else begin
          counter <= counter + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: doc/lat_sequencer.md
Name: lat_sequencer

Overview:
- Parametrised, command-driven successor to the FC setter timing generator. Produces the SCLK-aligned LAT pattern for a daisy chain of N_DRIVERS LED driver devices.
- Supports four frame types: FC write (FCWRTEN + WRTFC), WRTGS, LATGS and LINERESET.
- Also emits a data-phase enable that tells the serial shifter when to clock pixel/FC bits.
- Sits between the frame scheduler (command source) and the LED band controller shifters. SCLK is generated elsewhere and sampled here.

Parameters:
- N_DRIVERS, 1, number of chained driver devices per band.
- WORD_BITS, 48, bits per driver per frame.
- FCWRTEN_LEN, 15, LAT-high SCLK count for FCWRTEN.
- WRTFC_LEN, 5, LAT-high SCLK count for WRTFC.
- FC_ON_RESET, 1, when 1 an FC write frame starts automatically on reset release.
- Derived DATA_LEN = WORD_BITS*N_DRIVERS.
- Derived CNT_W = clog2(FCWRTEN_LEN+DATA_LEN+2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- SCLK  in  1  serial clock, synchronous to clk, sampled for rising edges.
- cmd_valid  in  1  command request.
- cmd  in  2  frame type: 0=FC write, 1=WRTGS, 2=LATGS, 3=LINERESET.
- cmd_ready  out  1  high when a command can be accepted.
- force_fc  in  1  one-clk pulse; abort the current frame and start an FC write.
- en  out  1  frame active.
- LAT  out  1  latch line to the drivers.
- data_phase  out  1  shifter must shift one bit per SCLK rising edge while high.
- done  out  1  one-clk pulse on completion of a frame.

Behaviour:
- Reset, asynchronous and active-high:
  - counter=0, prev_SCLK=0, done=0, mode=FC.
  - en=FC_ON_RESET, so with FC_ON_RESET=1 an FC frame runs from reset release.
- Edge detection: posedge_SCLK = SCLK & ~prev_SCLK, with prev_SCLK registered every clk.
- cmd_ready = ~en & ~force_fc.
- Command acceptance: on cmd_valid & cmd_ready, at that clk edge mode<=cmd, counter<=0, en<=1.
- Counter: increments by 1 on each posedge_SCLK while en=1 and holds otherwise. Width CNT_W; it never wraps because a frame ends first.
- FC frame (mode 0), last count L = FCWRTEN_LEN+DATA_LEN+1:
  - LAT high for counts 1..FCWRTEN_LEN.
  - LAT high for counts L-WRTFC_LEN..L-1.
  - data_phase high for counts FCWRTEN_LEN+1..L-1.
- Data frames (modes 1/2/3), last count L = DATA_LEN+1:
  - data_phase high for counts 1..DATA_LEN.
  - LAT high for the last k data counts, DATA_LEN-k+1..DATA_LEN, with k=1 for WRTGS, 3 for LATGS, 7 for LINERESET.
- Count 0 and count L: LAT=0 and data_phase=0 in every mode, giving one low-LAT SCLK at each frame boundary.
- LAT and data_phase are combinational decodes of the registered counter, mode and en only, with no input-to-output path. Both are 0 when en=0.
- Frame end: on posedge_SCLK with counter==L, en<=0, counter<=0, and done<=1 for exactly one clk.
- force_fc, any cycle, including mid-frame and idle: at the next edge mode<=FC, counter<=0, en<=1.
  - The aborted frame produces no done.
  - force_fc wins over a coincident posedge_SCLK, a coincident frame end (no done) and a coincident cmd_valid (command not accepted, stays pending).
- A frame ending and a new command arriving in the same clk: the command is not accepted until the following cycle, because cmd_ready was 0.
- Static constraints:
  - FCWRTEN_LEN+1 < L-WRTFC_LEN (no overlap of the two LAT windows).
  - DATA_LEN ≥ 7.

Test Plan:
1. Defaults, FC_ON_RESET=1, release rst, free-running SCLK:
   - en=1 from reset.
   - LAT high at counts 1..15 and 59..63.
   - data_phase high at counts 16..63.
   - en falls and done pulses once at the SCLK edge with counter=64.
2. Defaults, cmd=1 (WRTGS) accepted while idle:
   - data_phase for 48 SCLKs (counts 1..48).
   - LAT high only at count 48.
   - done at count 49.
   - cmd_ready=0 throughout the frame.
3. cmd=2 (LATGS) then cmd=3 (LINERESET), back-to-back:
   - LAT high for 46..48 in the first frame, then 42..48 in the second.
   - The second command is accepted exactly 1 clk after the first done.
4. N_DRIVERS=2, FC frame:
   - L=112.
   - LAT at counts 1..15 and 107..111.
   - data_phase for 96 SCLKs.
   - done at count 112.
5. force_fc during a WRTGS frame at count 30, coincident with a posedge_SCLK and with cmd_valid=1:
   - counter=0, mode=FC.
   - No done for the aborted frame; the command is held off.
   - A full 65-count FC frame follows.
6. Assert rst at FC count 60 with LAT high:
   - LAT=0 and done=0 immediately, without waiting for a clk edge.
   - After release, a fresh FC frame starts at counter 0.
   - With FC_ON_RESET=0, en=0 and cmd_ready=1 after release.
